// File: rtl/mealy_stream_arbiter.sv
// mealy_stream_arbiter: round-robin front end that shares one serial Mealy
// sequence detector between NREQ requesters. The winning word is shifted
// MSB-first into the detector, aout hits are counted, and the count is
// reported with the requester index on a one-cycle done pulse.
// Optional build macro MEALY_ARB_HITMAP_EN adds a per-bit hit_map output.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for any req; picks winner, latches word, issues grant
// CLEAR  | grant and det_clr high; internal counters zeroed
// SHIFT  | WORD_W cycles, one word bit per cycle on det_ain, hits counted
// REPORT | done high; done_id / hit_count hold the result until next REPORT
module mealy_stream_arbiter #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WORD_W-1:0]    data,
    output logic [NREQ-1:0]           grant,
    output logic                      det_clr,
    output logic                      det_ain,
    input  logic                      det_aout,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
`ifdef MEALY_ARB_HITMAP_EN
    output logic [WORD_W-1:0]         hit_map,
`endif
    output logic [CNT_W-1:0]          hit_count
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_SHIFT  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                det_clr_q, det_clr_d;
    logic                det_ain_q, det_ain_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    hit_int_q, hit_int_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [CNT_W-1:0]    hit_sum;
    logic [WORD_W-1:0]   map_int_q, map_int_d;
    logic [WORD_W-1:0]   map_sum;
    logic [WORD_W-1:0]   hit_map_q, hit_map_d;
    logic                win_valid;
    logic [ID_W-1:0]     win_idx;
    int                  idx;

    // Round-robin search: scan from farthest to nearest so the nearest set
    // request after last_q is the one left standing.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(last_q) + i) % NREQ;
            if (req[idx]) begin
                win_valid = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    // Next-state and datapath; det_aout is only looked at during SHIFT so an
    // undriven detector output elsewhere cannot leak into the result.
    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        det_clr_d   = 1'b0;
        det_ain_d   = 1'b0;
        last_d      = last_q;
        done_id_d   = done_id_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        hit_int_d   = hit_int_q;
        hit_count_d = hit_count_q;
        map_int_d   = map_int_q;
        hit_map_d   = hit_map_q;
        hit_sum     = '0;
        map_sum     = '0;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    shreg_d          = data[win_idx*WORD_W +: WORD_W];
                    last_d           = win_idx;
                    grant_d[win_idx] = 1'b1;
                    det_clr_d        = 1'b1;
                    state_d          = S_CLEAR;
                end
            end
            S_CLEAR: begin
                hit_int_d = '0;
                bit_cnt_d = '0;
                map_int_d = '0;
                det_ain_d = shreg_q[WORD_W-1];
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                hit_sum   = hit_int_q + CNT_W'(det_aout);
                map_sum   = {map_int_q[WORD_W-2:0], det_aout};
                hit_int_d = hit_sum;
                map_int_d = map_sum;
                shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                    hit_count_d = hit_sum;
                    hit_map_d   = map_sum;
                    done_id_d   = last_q;
                    state_d     = S_REPORT;
                end else begin
                    det_ain_d = shreg_q[WORD_W-2];
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            det_clr_q   <= 1'b0;
            det_ain_q   <= 1'b0;
            last_q      <= ID_W'(NREQ - 1);
            done_id_q   <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            hit_int_q   <= '0;
            hit_count_q <= '0;
            map_int_q   <= '0;
            hit_map_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            det_clr_q   <= det_clr_d;
            det_ain_q   <= det_ain_d;
            last_q      <= last_d;
            done_id_q   <= done_id_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            hit_int_q   <= hit_int_d;
            hit_count_q <= hit_count_d;
            map_int_q   <= map_int_d;
            hit_map_q   <= hit_map_d;
        end
    end

    assign grant     = grant_q;
    assign det_clr   = det_clr_q;
    assign det_ain   = det_ain_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_REPORT);
    assign done_id   = done_id_q;
    assign hit_count = hit_count_q;
`ifdef MEALY_ARB_HITMAP_EN
    assign hit_map   = hit_map_q;
`else
    // Without the hit map the bit-position shadow has no consumer.
    logic unused_map;
    assign unused_map = ^hit_map_q;
`endif

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// Directed bench for mealy_stream_arbiter (NREQ=4, WORD_W=8). A stub detector
// echoes det_ain (X outside the shift window); a small "110" Mealy detector
// model is switched in for the final test.
module tb_mealy_stream_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        det_clr;
    logic        det_ain;
    logic        det_aout;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  hit_count;
`ifdef MEALY_ARB_HITMAP_EN
    logic [7:0]  hit_map;
`endif

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   done_cnt = 0;
    bit   x_seen = 0;
    bit   viol   = 0;
    bit   use_real = 0;
    logic [1:0] rd_st;
    logic       rd_out;

    mealy_stream_arbiter #(.NREQ(4), .WORD_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .grant     (grant),
        .det_clr   (det_clr),
        .det_ain   (det_ain),
        .det_aout  (det_aout),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
`ifdef MEALY_ARB_HITMAP_EN
        .hit_map   (hit_map),
`endif
        .hit_count (hit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // "110" detector: aout=1 when in state 2 (seen 11) and ain=0.
    always @(posedge clock or negedge reset) begin
        if (!reset)        rd_st <= 2'd0;
        else if (det_clr)  rd_st <= 2'd0;
        else if (det_ain)  rd_st <= (rd_st == 2'd0) ? 2'd1 : 2'd2;
        else               rd_st <= 2'd0;
    end
    assign rd_out   = (rd_st == 2'd2) && !det_ain;
    assign det_aout = use_real ? rd_out : ((det_clr || done) ? 1'bx : det_ain);

    always @(negedge clock) begin
        if (reset) begin
            if ($isunknown(det_ain) || $isunknown(det_clr)) x_seen = 1;
            if ($countones(grant) > 1 || (grant != 0 && done)) viol = 1;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Waits for a grant, then follows the word through to done.
    task automatic run_one(input int exp_id, input logic [7:0] w, input int exp_hits,
                           input logic [7:0] exp_map, output int gcyc);
        int t;
        t = 0;
        gcyc = -1;
        while (grant == 0 && t < 30) begin
            @(negedge clock);
            t++;
        end
        check("grant_seen", 32'(grant != 0), 1);
        if (grant == 0) return;
        gcyc = cyc;
        check("grant_onehot", grant, 4'b1 << exp_id);
        check("det_clr", det_clr, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("det_ain", det_ain, w[7-k]);
        end
        @(negedge clock);
        check("done", done, 1);
        check("done_id", done_id, exp_id);
        check("hit_count", hit_count, exp_hits);
`ifdef MEALY_ARB_HITMAP_EN
        check("hit_map", hit_map, exp_map);
`else
        if (exp_map === 8'hxx) $display("note: map value unknown");
`endif
    endtask

    initial begin
        int g0, g1, t, dc;
        int ord[5];
        reset = 1'b0;
        req   = '0;
        data  = '0;
        repeat (4) @(negedge clock);
        check("rst_grant", grant, 0);
        check("rst_det_clr", det_clr, 0);
        check("rst_det_ain", det_ain, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_hit_count", hit_count, 0);
        reset = 1'b1;

        // Popcount, single request.
        @(negedge clock);
        data[7:0] = 8'hA5;
        req = 4'b0001;
        run_one(0, 8'hA5, 4, 8'hA5, g0);
        req = 4'b0000;
        @(negedge clock);
        check("report_to_idle_done", done, 0);
        check("report_to_idle_busy", busy, 0);

        // Rotation with all requests held, from a fresh pointer.
        do_reset();
        data = {8'h78, 8'h56, 8'h34, 8'h12};
        req  = 4'b1111;
        ord  = '{0, 1, 2, 3, 0};
        g0 = -1;
        foreach (ord[i]) begin
            logic [7:0] w;
            int ph;
            w  = data[ord[i]*8 +: 8];
            ph = $countones(w);
            run_one(ord[i], w, ph, w, g1);
            if (g0 >= 0) check("rot_spacing", g1 - g0, 11);
            g0 = g1;
        end
        req = 4'b0000;

        // Pointer fairness: serve 2, then 0101 must grant 0 then 2.
        @(negedge clock);
        req = 4'b0100;
        run_one(2, 8'h56, 4, 8'h56, g0);
        req = 4'b0101;
        run_one(0, 8'h12, 2, 8'h12, g0);
        run_one(2, 8'h56, 4, 8'h56, g1);
        req = 4'b0000;

        // Boundaries: all ones, all zeros, 0x81.
        @(negedge clock);
        data[15:8] = 8'hFF;
        req = 4'b0010;
        run_one(1, 8'hFF, 8, 8'hFF, g0);
        data[31:24] = 8'h00;
        req = 4'b1000;
        run_one(3, 8'h00, 0, 8'h00, g0);
        data[7:0] = 8'h81;
        req = 4'b0001;
        run_one(0, 8'h81, 2, 8'h81, g0);
        req = 4'b0000;

        // Reset on shift cycle 3.
        @(negedge clock);
        data[7:0] = 8'h3C;
        req = 4'b0001;
        t = 0;
        while (grant == 0 && t < 30) begin
            @(negedge clock);
            t++;
        end
        check("mid_grant_seen", 32'(grant != 0), 1);
        req = 4'b0000;
        repeat (4) @(negedge clock);
        dc = done_cnt;
        reset = 1'b0;
        #1;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_det_clr", det_clr, 0);
        check("mid_rst_det_ain", det_ain, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_done_id", done_id, 0);
        check("mid_rst_hit_count", hit_count, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        check("mid_no_done", done_cnt, dc);
        data[15:0] = {8'hF0, 8'h0F};
        req = 4'b0011;
        run_one(0, 8'h0F, 4, 8'h0F, g0);
        run_one(1, 8'hF0, 4, 8'hF0, g1);
        req = 4'b0000;

        // Real detector: 0110_0000 contains "110" once, hit on shift cycle 3.
        @(negedge clock);
        use_real = 1;
        data[7:0] = 8'h60;
        req = 4'b0001;
        run_one(0, 8'h60, 1, 8'h10, g0);
        req = 4'b0000;
        repeat (2) @(negedge clock);

        check("no_x_after_reset", 32'(x_seen), 0);
        check("grant_done_invariant", 32'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
